// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-sequencer state type.
package uart_pkg;
  localparam int unsigned UART_DATA_W          = 8;
  localparam int unsigned DEFAULT_DEPTH_LOG2   = 4;
  localparam int unsigned DEFAULT_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with separate level counter and synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      // A pop coinciding with flush still consumes its head entry.
      r_rptr  <= w_pop ? r_rptr + PTR_ONE : r_rptr;
      r_wptr  <= w_pop ? r_rptr + PTR_ONE : r_rptr;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
      else if (w_pop && !w_push) r_level <= r_level - LVL_ONE;
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue that launches one byte at a time into async_transmitter,
// waiting for TxD_busy to rise and fall (or time out) between launches.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
  parameter int unsigned BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic                   TxD_start,
  output logic [UART_DATA_W-1:0] TxD_data,
  input  logic                   TxD_busy,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   empty,
  output logic                   full,
  output logic                   idle
);
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT);

  tx_state_e              r_state;
  logic                   r_start;
  logic [UART_DATA_W-1:0] r_data;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_push;
  logic                   w_pop;
  logic [UART_DATA_W-1:0] w_rdata;

  assign wr_ready  = ~full & ~flush;
  assign w_push    = wr_valid & wr_ready;
  assign w_pop     = (r_state == IDLE) & ~empty & ~TxD_busy;
  assign idle      = empty & (r_state == IDLE);
  assign TxD_start = r_start;
  assign TxD_data  = r_data;

  sync_fifo #(
    .WIDTH      (UART_DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (wr_data),
    .o_rdata (w_rdata),
    .o_level (level),
    .o_full  (full),
    .o_empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_data  <= w_rdata;
            r_start <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TxD_busy) begin
            r_state <= WAIT_DONE;
          end else begin
            // Transmitter never acknowledged: treat the byte as sent.
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt + CNT_ONE == CNT_LAST) r_state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!TxD_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural transmitter model.
module tb_uart_tx_feeder;
  localparam int BUSY_LEN = 10;
  localparam int TIMEOUT  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       flush = 1'b0;
  logic       TxD_start;
  logic [7:0] TxD_data;
  logic       TxD_busy;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       idle;

  int checks = 0;
  int errors = 0;
  int max_level = 0;

  uart_tx_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .TxD_start (TxD_start),
    .TxD_data  (TxD_data),
    .TxD_busy  (TxD_busy),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: busy for BUSY_LEN cycles starting the cycle after a start pulse.
  int busy_cnt;
  bit model_en = 1'b1;
  bit force_busy = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (model_en && TxD_start) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign TxD_busy = (busy_cnt != 0) || force_busy;

  logic [7:0] mon_data[$];
  int         mon_cyc[$];
  always @(negedge clk) begin
    if (rst_n && TxD_start) begin
      mon_data.push_back(TxD_data);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic push(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = b;
    #1;
    while (!wr_ready && guard < 40) begin
      if (level > max_level) max_level = level;
      @(negedge clk);
      #1;
      guard++;
    end
    if (level > max_level) max_level = level;
    checks++;
    if (!wr_ready) begin
      errors++;
      $display("FAIL push_accept data=%h wr_ready=%b required 1", b, wr_ready);
    end
    @(posedge clk);
  endtask

  task automatic stop_push();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    @(negedge clk);
    while (!idle && n < bound) begin
      if (level > max_level) max_level = level;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL %s idle=%b required 1 within %0d cycles", name, idle, bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst0_level got %0d want 0", level); end
    checks++; if (TxD_data !== 8'h00) begin errors++; $display("FAIL rst0_data got %h want 00", TxD_data); end
    rst_n = 1'b1;
    // Put a byte in flight, then reset asynchronously mid-transmission.
    push(8'hC1); push(8'hC2); push(8'hC3);
    stop_push();
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", full); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b want 1", wr_ready); end
    checks++; if (TxD_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", TxD_start); end
    checks++; if (TxD_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", TxD_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b want 1", idle); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_rel_idle got %b want 1", idle); end
    checks++; if (TxD_data !== 8'h00) begin errors++; $display("FAIL rst_rel_data got %h want 00", TxD_data); end
  endtask

  task automatic test_single();
    int base = mon_data.size();
    int k = 0;
    push(8'hA5);
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (TxD_start !== 1'b0) begin errors++; $display("FAIL single_n_start got %b want 0", TxD_start); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_n_level got %0d want 1", level); end
    @(negedge clk);
    checks++; if (TxD_start !== 1'b1) begin errors++; $display("FAIL single_n1_start got %b want 1", TxD_start); end
    checks++; if (TxD_data !== 8'hA5) begin errors++; $display("FAIL single_n1_data got %h want a5", TxD_data); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_n1_level got %0d want 0", level); end
    @(negedge clk);
    checks++; if (TxD_start !== 1'b0) begin errors++; $display("FAIL single_n2_start got %b want 0", TxD_start); end
    checks++; if (TxD_data !== 8'hA5) begin errors++; $display("FAIL single_n2_data got %h want a5", TxD_data); end
    // Busy spans 10 cycles after the pulse; IDLE returns 11 cycles after this point.
    while (!idle && k < 30) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 11) begin errors++; $display("FAIL single_idle_delay got %0d want 11", k); end
    checks++; if (mon_data.size() !== base + 1) begin errors++; $display("FAIL single_count got %0d want %0d", mon_data.size(), base + 1); end
  endtask

  task automatic test_burst();
    int base = mon_data.size();
    force_busy = 1'b1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    @(negedge clk);
    wr_data = 8'h11;
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL burst_full got %b want 1", full); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL burst_wr_ready got %b want 0", wr_ready); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL burst_level got %0d want 16", level); end
    repeat (2) @(negedge clk);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL burst_stall_level got %0d want 16", level); end
    checks++; if (mon_data.size() !== base) begin errors++; $display("FAIL burst_foreign_busy launches=%0d want 0", mon_data.size() - base); end
    @(negedge clk);
    force_busy = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL burst_pop_cycle_ready got %b want 0", wr_ready); end
    @(negedge clk);
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL burst_after_pop_ready got %b want 1", wr_ready); end
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL burst_after_pop_level got %0d want 15", level); end
    checks++; if (TxD_data !== 8'h01) begin errors++; $display("FAIL burst_first_data got %h want 01", TxD_data); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL burst_refill_level got %0d want 16", level); end
    wait_idle(400, "burst_drain");
    checks++;
    if (mon_data.size() !== base + 17) begin
      errors++;
      $display("FAIL burst_count got %0d want 17", mon_data.size() - base);
    end else begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (mon_data[base + i] !== 8'(i + 1)) begin
          errors++;
          $display("FAIL burst_order[%0d] got %h want %h", i, mon_data[base + i], 8'(i + 1));
        end
      end
      // Busy duration plus two empty cycles between consecutive pulses.
      for (int i = 1; i < 17; i++) begin
        checks++;
        if (mon_cyc[base + i] - mon_cyc[base + i - 1] !== BUSY_LEN + 3) begin
          errors++;
          $display("FAIL burst_spacing[%0d] got %0d want %0d", i,
                   mon_cyc[base + i] - mon_cyc[base + i - 1], BUSY_LEN + 3);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int base = mon_data.size();
    max_level = 0;
    for (int i = 0; i < 24; i++) push(8'h40 + 8'(i));
    stop_push();
    wait_idle(24 * 13 + 40, "wrap_drain");
    checks++; if (max_level !== 16) begin errors++; $display("FAIL wrap_max_level got %0d want 16", max_level); end
    checks++;
    if (mon_data.size() !== base + 24) begin
      errors++;
      $display("FAIL wrap_count got %0d want 24", mon_data.size() - base);
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (mon_data[base + i] !== 8'h40 + 8'(i)) begin
          errors++;
          $display("FAIL wrap_order[%0d] got %h want %h", i, mon_data[base + i], 8'h40 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_flush();
    int base = mon_data.size();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h33 + 8'(i));
    @(negedge clk);
    force_busy = 1'b0;
    flush    = 1'b1;
    wr_data  = 8'h99;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL flush_wr_ready got %b want 0", wr_ready); end
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got %0d want 5", level); end
    @(negedge clk);
    flush    = 1'b0;
    wr_valid = 1'b0;
    #1;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", empty); end
    checks++; if (TxD_start !== 1'b1) begin errors++; $display("FAIL flush_start got %b want 1", TxD_start); end
    checks++; if (TxD_data !== 8'h33) begin errors++; $display("FAIL flush_data got %h want 33", TxD_data); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b want 1", wr_ready); end
    wait_idle(40, "flush_drain");
    checks++;
    if (mon_data.size() !== base + 1) begin
      errors++;
      $display("FAIL flush_count got %0d want 1", mon_data.size() - base);
    end
  endtask

  task automatic test_timeout();
    int base = mon_data.size();
    model_en = 1'b0;
    push(8'h51);
    push(8'h52);
    stop_push();
    wait_idle(60, "timeout_drain");
    model_en = 1'b1;
    checks++;
    if (mon_data.size() !== base + 2) begin
      errors++;
      $display("FAIL timeout_count got %0d want 2", mon_data.size() - base);
    end else begin
      checks++;
      if (mon_data[base + 1] !== 8'h52) begin
        errors++;
        $display("FAIL timeout_second_data got %h want 52", mon_data[base + 1]);
      end
      // START, TIMEOUT cycles in WAIT_BUSY, one IDLE cycle, then the next pulse.
      checks++;
      if (mon_cyc[base + 1] - mon_cyc[base] !== TIMEOUT + 2) begin
        errors++;
        $display("FAIL timeout_spacing got %0d want %0d",
                 mon_cyc[base + 1] - mon_cyc[base], TIMEOUT + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_flush();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
